// File: rtl/fifo_byte2nib_pkg.sv
// Shared widths, defaults and read-phase type for the byte-in / nibble-out FIFO.
// The nibble-to-byte companion FIFO uses the same definitions.
package fifo_byte2nib_pkg;

    localparam int BYTE_W    = 8;
    localparam int NIB_W     = 4;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;

    // Which half of the head byte the next read returns.
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    function automatic logic [NIB_W-1:0] nib_sel(input logic [BYTE_W-1:0] b,
                                                 input phase_t            ph);
        return (ph == PH_HI) ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
    endfunction

    function automatic phase_t phase_flip(input phase_t ph);
        return (ph == PH_HI) ? PH_LO : PH_HI;
    endfunction

endpackage

// File: rtl/fifo_byte2nib_if.sv
// Byte-write / nibble-read handshake bundle between a producer/consumer and the FIFO.
interface fifo_byte2nib_if
    import fifo_byte2nib_pkg::*;
();

    logic [BYTE_W-1:0] Data_In;
    logic              input_enable;
    logic              input_valid;
    logic [NIB_W-1:0]  Data_Out;
    logic              output_enable;
    logic              output_valid;

    modport master (
        output Data_In,
        output input_enable,
        input  input_valid,
        input  Data_Out,
        output output_enable,
        input  output_valid
    );

    modport slave (
        input  Data_In,
        input  input_enable,
        output input_valid,
        output Data_Out,
        input  output_enable,
        output output_valid
    );

endinterface

// File: rtl/fifo_byte2nib_ram.sv
// Byte storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_byte2nib_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_byte2nib.sv
// Byte-in / nibble-out FIFO: stores whole bytes, returns low nibble then high nibble.
// Occupancy is tracked in bytes; a half-read byte keeps its slot until its high nibble leaves.
module fifo_byte2nib
    import fifo_byte2nib_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fifo_byte2nib_if.slave bus
);

    localparam int CNT_W = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    phase_t            phase;
    logic [NIB_W-1:0]  dout_q;
    logic              in_vld_q;
    logic              out_vld_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_free;
    logic [BYTE_W-1:0] head_byte;

    // Acceptance uses only the registered flags, so enables never feed back into them.
    assign wr_acc  = bus.input_enable  & in_vld_q;
    assign rd_acc  = bus.output_enable & out_vld_q;
    assign rd_free = rd_acc & (phase == PH_HI);

    assign count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_free);

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr),
        .wdata (bus.Data_In),
        .raddr (rd_ptr),
        .rdata (head_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            phase     <= PH_LO;
            dout_q    <= '0;
            in_vld_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                dout_q <= nib_sel(head_byte, phase);
                phase  <= phase_flip(phase);
            end
            if (rd_free) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            in_vld_q  <= (count_nxt != CNT_W'(DEPTH));
            out_vld_q <= (count_nxt != '0);
        end
    end

    assign bus.Data_Out     = dout_q;
    assign bus.input_valid  = in_vld_q;
    assign bus.output_valid = out_vld_q;

    a_count_range : assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));
    a_full_flag : assert property (@(posedge clk) disable iff (rst)
        in_vld_q == (count != CNT_W'(DEPTH)));
    a_empty_flag : assert property (@(posedge clk) disable iff (rst)
        out_vld_q == (count != '0));

endmodule

// File: tb/tb_fifo_byte2nib.sv
// Bench for fifo_byte2nib: directed table, multi-cycle corner sequences and a random soak
// against a nibble-queue reference model.
module tb_fifo_byte2nib;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    fifo_byte2nib_if bus ();

    fifo_byte2nib #(
        .DEPTH (DEPTH),
        .AW    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the FIFO contents as a plain stream of nibbles in delivery order.
    logic [3:0] mq [$];
    logic [3:0] m_dout;

    typedef struct {
        logic       ie;
        logic [7:0] din;
        logic       oe;
        logic [3:0] dout;
        logic       iv;
        logic       ov;
        int         cnt;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_bytes();
        return (mq.size() + 1) / 2;
    endfunction

    // One clock: drive inputs, advance the model, then check the DUT against the model.
    task automatic cycle(input logic ie, input logic [7:0] din, input logic oe, input logic r);
        bit wr;
        bit rd;
        bus.input_enable  = ie;
        bus.Data_In       = din;
        bus.output_enable = oe;
        rst               = r;
        if (r) begin
            mq.delete();
            m_dout = 4'h0;
        end else begin
            wr = ie && (model_bytes() < DEPTH);
            rd = oe && (mq.size() > 0);
            if (rd) m_dout = mq.pop_front();
            if (wr) begin
                mq.push_back(din[3:0]);
                mq.push_back(din[7:4]);
            end
        end
        @(posedge clk);
        #1;
        chk("model_dout", int'(bus.Data_Out), int'(m_dout));
        chk("model_in_valid", int'(bus.input_valid), int'(model_bytes() < DEPTH));
        chk("model_out_valid", int'(bus.output_valid), int'(mq.size() > 0));
        chk("model_count", int'(dut.count), model_bytes());
    endtask

    task automatic idle();
        bus.input_enable  = 1'b0;
        bus.output_enable = 1'b0;
        bus.Data_In       = 8'h00;
        rst               = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b1, 8'h5A, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.input_enable  = 1'b1;
        bus.output_enable = 1'b0;
        bus.Data_In       = 8'h00;
        m_dout            = 4'h0;

        //                ie    din    oe    dout  iv    ov    cnt
        tv[0] = '{1'b1, 8'hA5, 1'b0, 4'h0, 1'b1, 1'b1, 1};
        tv[1] = '{1'b1, 8'h3C, 1'b0, 4'h0, 1'b1, 1'b1, 2};
        tv[2] = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b1, 1'b1, 2};
        tv[3] = '{1'b0, 8'h00, 1'b1, 4'hA, 1'b1, 1'b1, 1};
        tv[4] = '{1'b0, 8'h00, 1'b1, 4'hC, 1'b1, 1'b1, 1};
        tv[5] = '{1'b0, 8'h00, 1'b1, 4'h3, 1'b1, 1'b0, 0};

        // Reset held two cycles with a write request pending
        do_reset();
        chk("reset_count", int'(dut.count), 0);
        chk("reset_in_valid", int'(bus.input_valid), 1);
        chk("reset_out_valid", int'(bus.output_valid), 0);
        chk("reset_dout", int'(bus.Data_Out), 0);

        // Ordering of two bytes, table-driven
        for (int i = 0; i < 6; i++) begin
            cycle(tv[i].ie, tv[i].din, tv[i].oe, 1'b0);
            chk($sformatf("order_dout[%0d]", i), int'(bus.Data_Out), int'(tv[i].dout));
            chk($sformatf("order_iv[%0d]", i), int'(bus.input_valid), int'(tv[i].iv));
            chk($sformatf("order_ov[%0d]", i), int'(bus.output_valid), int'(tv[i].ov));
            chk($sformatf("order_cnt[%0d]", i), int'(dut.count), tv[i].cnt);
        end

        // Fill to full, ignored 9th write, then drain 16 nibbles
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        chk("full_in_valid", int'(bus.input_valid), 0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("full_ignore_cnt", int'(dut.count), 8);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("full_drain[%0d]", i), int'(bus.Data_Out),
                (i % 2 == 0) ? (i / 2) : 1);
        end
        chk("full_drain_ov", int'(bus.output_valid), 0);

        // Half-read byte keeps the FIFO full
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("partial_iv_after_lo", int'(bus.input_valid), 0);
        chk("partial_lo_nib", int'(bus.Data_Out), 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("partial_iv_after_hi", int'(bus.input_valid), 1);
        chk("partial_hi_nib", int'(bus.Data_Out), 4'hC);
        for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("partial_drained", int'(bus.output_valid), 0);

        // Simultaneous read and write with two bytes held
        do_reset();
        cycle(1'b1, 8'h21, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        chk("simul_cnt_start", int'(dut.count), 2);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h65 + 8'h22 * i), 1'b1, 1'b0);
            chk($sformatf("simul_cnt[%0d]", i), int'(dut.count), (i < 2) ? 3 : 4);
        end
        chk("simul_nib4", int'(bus.Data_Out), 4'h4);
        while (mq.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random soak with a reset in the middle
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                cycle($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b1);
                chk("soak_rst_dout", int'(bus.Data_Out), 0);
                chk("soak_rst_cnt", int'(dut.count), 0);
                chk("soak_rst_ov", int'(bus.output_valid), 0);
            end else begin
                cycle($urandom_range(0, 99) < 55, 8'($urandom),
                      $urandom_range(0, 99) < 50, 1'b0);
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
